regfile_scoreboard: RTL and testbench

//  Parametrised integer register file for the RV32 core with N combinational read ports,
//  one write port, optional write-to-read bypass and a per-register busy scoreboard.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/reg_busy_tracker.sv | 51 +++++
 rtl/regfile_scoreboard.sv | 81 ++++++++
 tb/tb_regfile_scoreboard.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the integer register file and its busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;

  // Index of the hardwired-zero register x0.
  localparam int unsigned REG_ZERO = '0;

  // True for an address that maps to real storage (not x0, not past the last register).
  function automatic logic rf_addr_valid(input int unsigned addr, input int unsigned nregs);
    return (addr != REG_ZERO) && (addr < nregs);
  endfunction

endpackage

// File: rtl/reg_busy_tracker.sv
// Per-register busy scoreboard: issue reserves a destination, writeback releases it.
module reg_busy_tracker
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_write,
  input  logic [AW-1:0]    i_waddr,
  input  logic             i_rsv,
  input  logic [AW-1:0]    i_rsv_addr,
  output logic             o_rsv_ready,
  output logic [NREGS-1:0] o_busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic             wr_ok;
  logic             rsv_valid;
  logic             rsv_ok;

  assign wr_ok     = i_write && rf_addr_valid(32'(i_waddr), NREGS);
  assign rsv_valid = rf_addr_valid(32'(i_rsv_addr), NREGS);

  // A pending write to the same register this cycle frees it, so the reservation can chain.
  always_comb begin
    o_rsv_ready = 1'b1;
    if (rsv_valid) begin
      o_rsv_ready = ~busy_q[i_rsv_addr] | (i_write && (i_waddr == i_rsv_addr));
    end
  end

  assign rsv_ok     = i_rsv && o_rsv_ready && rsv_valid;
  assign o_busy_vec = busy_q;

  // Release on writeback, then set on reservation so a same-register reserve wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_q <= '0;
    end else begin
      if (wr_ok) begin
        busy_q[i_waddr] <= 1'b0;
      end
      if (rsv_ok) begin
        busy_q[i_rsv_addr] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with N combinational read ports, one write port,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NREAD  = NREAD_DEF,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREAD*AW-1:0]   i_raddr,
  output logic [NREAD*XLEN-1:0] o_rdata,
  output logic [NREAD-1:0]      o_rbusy,
  input  logic                  i_write,
  input  logic [AW-1:0]         i_waddr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic                  i_rsv,
  input  logic [AW-1:0]         i_rsv_addr,
  output logic                  o_rsv_ready,
  output logic [NREGS-1:0]      o_busy_vec
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wr_ok;

  assign wr_ok = i_write && rf_addr_valid(32'(i_waddr), NREGS);

  reg_busy_tracker #(
    .NREGS(NREGS)
  ) u_busy (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_write    (i_write),
    .i_waddr    (i_waddr),
    .i_rsv      (i_rsv),
    .i_rsv_addr (i_rsv_addr),
    .o_rsv_ready(o_rsv_ready),
    .o_busy_vec (o_busy_vec)
  );

  // Data array; x0 is cleared at reset and never written, so it always reads as zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdata;
    logic            rbusy;

    assign ra = i_raddr[k*AW +: AW];

    // Read mux: invalid addresses return zero/not-busy; bypass forwards the in-flight write.
    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if (rf_addr_valid(32'(ra), NREGS)) begin
        if ((BYPASS != 0) && i_write && (i_waddr == ra)) begin
          rdata = i_wdata;
          rbusy = 1'b0;
        end else begin
          rdata = mem[ra];
          rbusy = o_busy_vec[ra];
        end
      end
    end

    assign o_rdata[k*XLEN +: XLEN] = rdata;
    assign o_rbusy[k]              = rbusy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: default parameters, bypass on.
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_write;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        a_rsv;
  logic [4:0]  a_rsv_addr;
  logic        a_rsv_ready;
  logic [31:0] a_busy_vec;

  // Instance B: 20 registers, 3 read ports, bypass off.
  logic [14:0] b_raddr;
  logic [95:0] b_rdata;
  logic [2:0]  b_rbusy;
  logic        b_write;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        b_rsv;
  logic [4:0]  b_rsv_addr;
  logic        b_rsv_ready;
  logic [19:0] b_busy_vec;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_raddr(a_raddr), .o_rdata(a_rdata), .o_rbusy(a_rbusy),
    .i_write(a_write), .i_waddr(a_waddr), .i_wdata(a_wdata),
    .i_rsv(a_rsv), .i_rsv_addr(a_rsv_addr), .o_rsv_ready(a_rsv_ready),
    .o_busy_vec(a_busy_vec)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(20), .NREAD(3), .BYPASS(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_raddr(b_raddr), .o_rdata(b_rdata), .o_rbusy(b_rbusy),
    .i_write(b_write), .i_waddr(b_waddr), .i_wdata(b_wdata),
    .i_rsv(b_rsv), .i_rsv_addr(b_rsv_addr), .o_rsv_ready(b_rsv_ready),
    .o_busy_vec(b_busy_vec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_write = 0; a_waddr = 0; a_wdata = 0; a_rsv = 0; a_rsv_addr = 0; a_raddr = 0;
    b_write = 0; b_waddr = 0; b_wdata = 0; b_rsv = 0; b_rsv_addr = 0; b_raddr = 0;
  endtask

  task automatic test_reset();
    a_write = 1; a_waddr = 5; a_wdata = 32'hDEAD_BEEF;
    a_rsv = 1; a_rsv_addr = 6;
    tick();
    a_write = 0; a_rsv = 0;
    a_raddr = {5'd6, 5'd5};
    #1;
    n_checks++;
    if (a_rdata[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL reset_pre_x5: got %h want %h", a_rdata[31:0], 32'hDEAD_BEEF);
    end
    n_checks++;
    if (a_busy_vec !== 32'h0000_0040) begin
      n_fail++; $display("FAIL reset_pre_busy: got %h want %h", a_busy_vec, 32'h0000_0040);
    end
    // Reset must override a same-cycle write and reserve.
    rst_n = 0;
    a_write = 1; a_waddr = 5; a_wdata = 32'h1111_1111;
    a_rsv = 1; a_rsv_addr = 9;
    tick();
    rst_n = 1;
    a_write = 0; a_rsv = 0;
    #1;
    n_checks++;
    if (a_rdata !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want %h", a_rdata, 64'h0);
    end
    n_checks++;
    if (a_busy_vec !== 32'h0) begin
      n_fail++; $display("FAIL reset_busy_vec: got %h want %h", a_busy_vec, 32'h0);
    end
    n_checks++;
    if (a_rbusy !== 2'b00) begin
      n_fail++; $display("FAIL reset_rbusy: got %b want %b", a_rbusy, 2'b00);
    end
    n_checks++;
    if (a_rsv_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_rsv_ready: got %b want %b", a_rsv_ready, 1'b1);
    end
    n_checks++;
    if (b_busy_vec !== 20'h0 || b_rdata !== 96'h0) begin
      n_fail++; $display("FAIL reset_b_state: got busy %h rdata %h want 0", b_busy_vec, b_rdata);
    end
  endtask

  task automatic test_x0();
    a_write = 1; a_waddr = 0; a_wdata = 32'h1234;
    a_rsv = 1; a_rsv_addr = 0;
    a_raddr = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (a_rsv_ready !== 1'b1) begin
      n_fail++; $display("FAIL x0_rsv_ready: got %b want %b", a_rsv_ready, 1'b1);
    end
    n_checks++;
    if (a_rdata[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL x0_no_bypass: got %h want %h", a_rdata[31:0], 32'h0);
    end
    tick();
    a_write = 0; a_rsv = 0;
    #1;
    n_checks++;
    if (a_rdata[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL x0_read: got %h want %h", a_rdata[31:0], 32'h0);
    end
    n_checks++;
    if (a_busy_vec !== 32'h0) begin
      n_fail++; $display("FAIL x0_busy_vec: got %h want %h", a_busy_vec, 32'h0);
    end
  endtask

  task automatic test_bypass();
    a_write = 1; a_waddr = 7; a_wdata = 32'hA5A5_A5A5;
    a_raddr = {5'd7, 5'd0};
    #1;
    n_checks++;
    if (a_rdata[63:32] !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h want %h", a_rdata[63:32], 32'hA5A5_A5A5);
    end
    tick();
    a_write = 0;
    #1;
    n_checks++;
    if (a_rdata[63:32] !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL bypass_stored: got %h want %h", a_rdata[63:32], 32'hA5A5_A5A5);
    end
    // Without bypass the old value is seen until the edge.
    b_write = 1; b_waddr = 7; b_wdata = 32'h11;
    tick();
    b_waddr = 7; b_wdata = 32'h22;
    b_raddr = {5'd7, 5'd0, 5'd0};
    #1;
    n_checks++;
    if (b_rdata[95:64] !== 32'h11) begin
      n_fail++; $display("FAIL nobypass_old: got %h want %h", b_rdata[95:64], 32'h11);
    end
    tick();
    b_write = 0;
    #1;
    n_checks++;
    if (b_rdata[95:64] !== 32'h22) begin
      n_fail++; $display("FAIL nobypass_new: got %h want %h", b_rdata[95:64], 32'h22);
    end
  endtask

  task automatic test_scoreboard();
    a_rsv = 1; a_rsv_addr = 3;
    a_raddr = {5'd0, 5'd3};
    #1;
    n_checks++;
    if (a_rsv_ready !== 1'b1) begin
      n_fail++; $display("FAIL sb_first_ready: got %b want %b", a_rsv_ready, 1'b1);
    end
    tick();
    #1;
    n_checks++;
    if (a_rbusy[0] !== 1'b1) begin
      n_fail++; $display("FAIL sb_rbusy_set: got %b want %b", a_rbusy[0], 1'b1);
    end
    n_checks++;
    if (a_rsv_ready !== 1'b0) begin
      n_fail++; $display("FAIL sb_waw_stall: got %b want %b", a_rsv_ready, 1'b0);
    end
    tick();
    a_rsv = 0;
    #1;
    n_checks++;
    if (a_busy_vec !== 32'h0000_0008) begin
      n_fail++; $display("FAIL sb_busy_unchanged: got %h want %h", a_busy_vec, 32'h0000_0008);
    end
    a_write = 1; a_waddr = 3; a_wdata = 32'h42;
    #1;
    n_checks++;
    if (a_rdata[31:0] !== 32'h42 || a_rbusy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_bypass_release: got %h/%b want %h/%b", a_rdata[31:0], a_rbusy[0], 32'h42, 1'b0);
    end
    tick();
    a_write = 0;
    #1;
    n_checks++;
    if (a_busy_vec !== 32'h0 || a_rbusy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_busy_cleared: got %h/%b want %h/%b", a_busy_vec, a_rbusy[0], 32'h0, 1'b0);
    end
    n_checks++;
    if (a_rdata[31:0] !== 32'h42) begin
      n_fail++; $display("FAIL sb_readback: got %h want %h", a_rdata[31:0], 32'h42);
    end
  endtask

  task automatic test_simultaneous();
    a_rsv = 1; a_rsv_addr = 4;
    tick();
    a_write = 1; a_waddr = 4; a_wdata = 32'h99;
    a_rsv = 1; a_rsv_addr = 4;
    #1;
    n_checks++;
    if (a_rsv_ready !== 1'b1) begin
      n_fail++; $display("FAIL simul_ready: got %b want %b", a_rsv_ready, 1'b1);
    end
    tick();
    a_write = 0; a_rsv = 0;
    a_raddr = {5'd4, 5'd0};
    #1;
    n_checks++;
    if (a_rdata[63:32] !== 32'h99) begin
      n_fail++; $display("FAIL simul_data: got %h want %h", a_rdata[63:32], 32'h99);
    end
    n_checks++;
    if (a_busy_vec !== 32'h0000_0010 || a_rbusy[1] !== 1'b1) begin
      n_fail++; $display("FAIL simul_busy: got %h/%b want %h/%b", a_busy_vec, a_rbusy[1], 32'h0000_0010, 1'b1);
    end
  endtask

  task automatic test_params();
    b_write = 1; b_waddr = 25; b_wdata = 32'hFFFF_FFFF;
    b_rsv = 1; b_rsv_addr = 25;
    #1;
    n_checks++;
    if (b_rsv_ready !== 1'b1) begin
      n_fail++; $display("FAIL param_oor_ready: got %b want %b", b_rsv_ready, 1'b1);
    end
    tick();
    b_write = 0; b_rsv = 0;
    b_raddr = {5'd7, 5'd25, 5'd25};
    #1;
    n_checks++;
    if (b_rdata[63:0] !== 64'h0 || b_rbusy[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL param_oor_read: got %h/%b want 0/0", b_rdata[63:0], b_rbusy[1:0]);
    end
    n_checks++;
    if (b_busy_vec !== 20'h0 || b_rdata[95:64] !== 32'h22) begin
      n_fail++; $display("FAIL param_oor_nochange: got %h/%h want %h/%h", b_busy_vec, b_rdata[95:64], 20'h0, 32'h22);
    end
    b_write = 1;
    b_waddr = 1;  b_wdata = 32'h101; tick();
    b_waddr = 10; b_wdata = 32'h10A; tick();
    b_waddr = 19; b_wdata = 32'h113; tick();
    b_write = 0;
    b_raddr = {5'd19, 5'd10, 5'd1};
    #1;
    n_checks++;
    if (b_rdata !== {32'h113, 32'h10A, 32'h101}) begin
      n_fail++; $display("FAIL param_three_ports: got %h want %h", b_rdata, {32'h113, 32'h10A, 32'h101});
    end
  endtask

  task automatic test_random();
    logic [31:0] m_reg [20];
    bit          m_busy [20];
    int unsigned ra [3];
    logic [31:0] exp_d;
    logic        exp_b;
    logic        exp_rdy;
    logic [19:0] exp_vec;
    bit          wvalid, rvalid;

    rst_n = 0;
    idle_inputs();
    tick();
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 0;
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      b_write    = ($urandom_range(0, 1) != 0);
      b_waddr    = 5'($urandom_range(0, 31));
      b_wdata    = $urandom;
      b_rsv      = ($urandom_range(0, 1) != 0);
      b_rsv_addr = 5'($urandom_range(0, 23));
      for (int k = 0; k < 3; k++) begin
        ra[k] = (k == 0) ? 32'(b_rsv_addr) : $urandom_range(0, 23);
        b_raddr[k*5 +: 5] = 5'(ra[k]);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        exp_d = '0;
        exp_b = 1'b0;
        if (ra[k] != 0 && ra[k] < 20) begin
          exp_d = m_reg[ra[k]];
          exp_b = m_busy[ra[k]];
        end
        n_checks++;
        if (b_rdata[k*32 +: 32] !== exp_d || b_rbusy[k] !== exp_b) begin
          n_fail++;
          $display("FAIL rand_read cyc %0d port %0d addr %0d: got %h/%b want %h/%b",
                   cyc, k, ra[k], b_rdata[k*32 +: 32], b_rbusy[k], exp_d, exp_b);
        end
      end
      rvalid  = (b_rsv_addr != 0) && (b_rsv_addr < 20);
      wvalid  = b_write && (b_waddr != 0) && (b_waddr < 20);
      exp_rdy = rvalid ? (!m_busy[b_rsv_addr] || (b_write && b_waddr == b_rsv_addr)) : 1'b1;
      n_checks++;
      if (b_rsv_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready cyc %0d addr %0d: got %b want %b", cyc, b_rsv_addr, b_rsv_ready, exp_rdy);
      end
      for (int i = 0; i < 20; i++) exp_vec[i] = m_busy[i];
      n_checks++;
      if (b_busy_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rand_busy_vec cyc %0d: got %h want %h", cyc, b_busy_vec, exp_vec);
      end
      if (!rst_n) begin
        for (int i = 0; i < 20; i++) begin
          m_reg[i] = '0;
          m_busy[i] = 0;
        end
      end else begin
        if (wvalid) begin
          m_reg[b_waddr]  = b_wdata;
          m_busy[b_waddr] = 0;
        end
        if (b_rsv && exp_rdy && rvalid) m_busy[b_rsv_addr] = 1;
      end
      tick();
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1;
    test_reset();
    idle_inputs();
    test_x0();
    idle_inputs();
    test_bypass();
    idle_inputs();
    test_scoreboard();
    idle_inputs();
    test_simultaneous();
    idle_inputs();
    test_params();
    idle_inputs();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
